// File: rtl/w_cmp_seq_if.sv
// Handshake/operand bundle for the sequential slice comparator w_cmp_seq.
// The master issues compares; the slave (the comparator) returns the result.
interface w_cmp_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             iagb;
  logic             iasb;
  logic             iaeb;
  logic             qagb;
  logic             qasb;
  logic             qaeb;
  logic             busy;
  logic             done;

  modport master (
    output start, dataa, datab, iagb, iasb, iaeb,
    input  qagb, qasb, qaeb, busy, done
  );

  modport slave (
    input  start, dataa, datab, iagb, iasb, iaeb,
    output qagb, qasb, qaeb, busy, done
  );
endinterface

// File: rtl/w_cmp_seq.sv
// Sequential MSB-first magnitude comparator, SLICE bits per clock, early exit,
// 74HC85-style cascade inputs. Define CMP_SIGNED_EN for two's-complement operands.
module w_cmp_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic        clk,
  input  logic        rst,
  w_cmp_seq_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [WIDTH-1:0] a_r, a_nxt;
  logic [WIDTH-1:0] b_r, b_nxt;
  logic [2:0]       casc_r, casc_nxt;
  logic [2:0]       q_r, q_nxt;
  logic [SLICE-1:0] slice_a, slice_b;
  logic             sign_split;
  logic             accept;
  logic [2:0]       casc_q;

  // Operands are shifted left after each equal slice, so the active slice is always on top.
  assign slice_a = a_r[WIDTH-1 -: SLICE];
  assign slice_b = b_r[WIDTH-1 -: SLICE];

`ifdef CMP_SIGNED_EN
  assign sign_split = (k == '0) && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
`else
  assign sign_split = 1'b0;
`endif

  // Cascade truth table, result packed as {gt, lt, eq}.
  always_comb begin
    casc_q = 3'b000;
    if (casc_r[0])
      casc_q = 3'b001;
    else begin
      case (casc_r[2:1])
        2'b10:   casc_q = 3'b100;
        2'b01:   casc_q = 3'b010;
        2'b11:   casc_q = 3'b000;
        default: casc_q = 3'b110;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    a_nxt     = a_r;
    b_nxt     = b_r;
    casc_nxt  = casc_r;
    q_nxt     = q_r;
    accept    = 1'b0;

    case (state)
      ST_IDLE: begin
        accept = bus.start;
      end
      ST_COMPARE: begin
        if (sign_split) begin
          q_nxt     = a_r[WIDTH-1] ? 3'b010 : 3'b100;
          state_nxt = ST_DONE;
        end else if (slice_a > slice_b) begin
          q_nxt     = 3'b100;
          state_nxt = ST_DONE;
        end else if (slice_a < slice_b) begin
          q_nxt     = 3'b010;
          state_nxt = ST_DONE;
        end else if (k == KLAST) begin
          q_nxt     = casc_q;
          state_nxt = ST_DONE;
        end else begin
          k_nxt = k + KW'(1);
          a_nxt = a_r << SLICE;
          b_nxt = b_r << SLICE;
        end
      end
      ST_DONE: begin
        accept    = bus.start;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Q is left untouched on accept so the previous result stays visible.
    if (accept) begin
      a_nxt     = bus.dataa;
      b_nxt     = bus.datab;
      casc_nxt  = {bus.iagb, bus.iasb, bus.iaeb};
      k_nxt     = '0;
      state_nxt = ST_COMPARE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      k      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      casc_r <= '0;
      q_r    <= '0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      casc_r <= casc_nxt;
      q_r    <= q_nxt;
    end
  end

  assign bus.qagb = q_r[2];
  assign bus.qasb = q_r[1];
  assign bus.qaeb = q_r[0];
  assign bus.busy = (state == ST_COMPARE);
  assign bus.done = (state == ST_DONE);
endmodule

// File: tb/tb_w_cmp_seq.sv
// Directed bench for w_cmp_seq (16-bit, 4-bit slices); expectations follow
// CMP_SIGNED_EN when the design is built with it.
module tb_w_cmp_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  w_cmp_seq_if #(.WIDTH(16)) bus ();

  w_cmp_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Call at a negedge; returns at the negedge on which done is seen (or after the bound).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [2:0] casc,
                               output int latency, output int busyCycles);
    bus.start = 1'b1;
    bus.dataa = a;
    bus.datab = b;
    {bus.iagb, bus.iasb, bus.iaeb} = casc;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataa = ~a;
    bus.datab = ~b;
    {bus.iagb, bus.iasb, bus.iaeb} = ~casc;
    latency    = -1;
    busyCycles = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy) busyCycles++;
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        latency = i;
        break;
      end
    end
  endtask

  function automatic logic [2:0] qVec();
    return {bus.qagb, bus.qasb, bus.qaeb};
  endfunction

  logic [2:0] cascTab [4] = '{3'b001, 3'b100, 3'b110, 3'b000};
  logic [2:0] qTab    [4] = '{3'b001, 3'b100, 3'b000, 3'b110};

  initial begin
    int lat;
    int bsy;
    bit sawDone;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0;
    bus.dataa = '0;
    bus.datab = '0;
    bus.iagb  = 1'b0;
    bus.iasb  = 1'b0;
    bus.iaeb  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_q", 32'(qVec()), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h8000, 16'h7FFF, 3'b001, lat, bsy);
    checkOutput("msb_lat", 32'(lat), 32'd1);
`ifdef CMP_SIGNED_EN
    checkOutput("msb_q", 32'(qVec()), 32'b010);
`else
    checkOutput("msb_q", 32'(qVec()), 32'b100);
`endif
    checkOutput("done_busy_low", 32'(bus.busy), 32'h0);
    @(negedge clk);
    checkOutput("done_pulse_one", 32'(bus.done), 32'h0);

    applyStimulus(16'h1234, 16'h1235, 3'b001, lat, bsy);
    checkOutput("lsb_lat", 32'(lat), 32'd4);
    checkOutput("lsb_busy", 32'(bsy), 32'd4);
    checkOutput("lsb_q", 32'(qVec()), 32'b010);
    @(negedge clk);

    for (int c = 0; c < 4; c++) begin
      applyStimulus(16'hBEEF, 16'hBEEF, cascTab[c], lat, bsy);
      checkOutput($sformatf("casc%0d_lat", c), 32'(lat), 32'd4);
      checkOutput($sformatf("casc%0d_q", c), 32'(qVec()), 32'(qTab[c]));
      @(negedge clk);
    end

    // Second START lands while busy and must not disturb the latched operands.
    bus.start = 1'b1;
    bus.dataa = 16'h00F0;
    bus.datab = 16'h00F1;
    {bus.iagb, bus.iasb, bus.iaeb} = 3'b001;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dataa = 16'hFFFF;
    bus.datab = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_start_nodone", 32'(bus.done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_start_nodone3", 32'(bus.done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_start_done4", 32'(bus.done), 32'h1);
    checkOutput("busy_start_q", 32'(qVec()), 32'b010);
    @(negedge clk);

    // Back-to-back: second START is driven during the DONE cycle of the first.
    applyStimulus(16'h5000, 16'h4000, 3'b001, lat, bsy);
    checkOutput("b2b_first_lat", 32'(lat), 32'd1);
    checkOutput("b2b_first_q", 32'(qVec()), 32'b100);
    bus.start = 1'b1;
    bus.dataa = 16'h0010;
    bus.datab = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2b_accept_busy", 32'(bus.busy), 32'h1);
    checkOutput("b2b_q_held", 32'(qVec()), 32'b100);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_second_done", 32'(bus.done), 32'h1);
    checkOutput("b2b_second_q", 32'(qVec()), 32'b010);
    @(negedge clk);

    // Reset during an equal-operand compare at cycle 2.
    sawDone = 1'b0;
    bus.start = 1'b1;
    bus.dataa = 16'hBEEF;
    bus.datab = 16'hBEEF;
    {bus.iagb, bus.iasb, bus.iaeb} = 3'b001;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_q", 32'(qVec()), 32'h0);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) sawDone = 1'b1;
    end
    checkOutput("abort_nodone", 32'(sawDone), 32'h0);

    applyStimulus(16'h0003, 16'h0002, 3'b001, lat, bsy);
    checkOutput("after_abort_lat", 32'(lat), 32'd4);
    checkOutput("after_abort_q", 32'(qVec()), 32'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
